// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model: INCR write and read bursts into a shared register-array memory.
// Unsupported burst type or beat size completes the burst with SLVERR and no memory effect.
module axi_mem_responder #(
  parameter int HP_ADDR_WIDTH = 48,
  parameter int HP_DATA_WIDTH = 128,
  parameter int MEM_DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
  input  logic [7:0]                 hp_awlen,
  input  logic [2:0]                 hp_awsize,
  input  logic [1:0]                 hp_awburst,
  input  logic                       hp_awvalid,
  output logic                       hp_awready,
  input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
  input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
  input  logic                       hp_wlast,
  input  logic                       hp_wvalid,
  output logic                       hp_wready,
  output logic [1:0]                 hp_bresp,
  output logic                       hp_bvalid,
  input  logic                       hp_bready,
  input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
  input  logic [7:0]                 hp_arlen,
  input  logic [2:0]                 hp_arsize,
  input  logic [1:0]                 hp_arburst,
  input  logic                       hp_arvalid,
  output logic                       hp_arready,
  output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
  output logic [1:0]                 hp_rresp,
  output logic                       hp_rlast,
  output logic                       hp_rvalid,
  input  logic                       hp_rready,
  output logic [31:0]                wr_beat_count,
  output logic [31:0]                rd_beat_count
);

  localparam int         STRB_W      = HP_DATA_WIDTH / 8;
  localparam int         LSB         = $clog2(STRB_W);
  localparam int         IDX_W       = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE_CODE   = 3'(LSB);
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [HP_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  w_state_t         w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len;
  logic [7:0]       w_cnt;
  logic             w_err;
  logic             w_over;

  r_state_t         r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len;
  logic [7:0]       r_cnt;
  logic             r_err;

  logic w_beat;
  logic r_beat;
  logic aw_err;
  logic ar_err;
  logic unused_addr_bits;

  assign w_beat = hp_wready & hp_wvalid;
  assign r_beat = hp_rvalid & hp_rready;
  assign aw_err = (hp_awburst != BURST_INCR) || (hp_awsize != SIZE_CODE);
  assign ar_err = (hp_arburst != BURST_INCR) || (hp_arsize != SIZE_CODE);

  // Address bits outside the memory index alias onto the same locations.
  assign unused_addr_bits = ^{hp_awaddr[HP_ADDR_WIDTH-1:LSB+IDX_W], hp_awaddr[LSB-1:0],
                              hp_araddr[HP_ADDR_WIDTH-1:LSB+IDX_W], hp_araddr[LSB-1:0]};

  always_ff @(posedge clk) begin
    if (w_beat && !w_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (hp_wstrb[b]) mem[w_idx][8*b +: 8] <= hp_wdata[8*b +: 8];
      end
    end
  end

  // Read data is combinational off the current index so a same-cycle write is seen next beat.
  assign hp_rdata = (hp_rvalid && !r_err) ? mem[r_idx] : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state       <= W_IDLE;
      hp_awready    <= 1'b0;
      hp_wready     <= 1'b0;
      hp_bvalid     <= 1'b0;
      hp_bresp      <= RESP_OKAY;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
      w_over        <= 1'b0;
      wr_beat_count <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (hp_awvalid && hp_awready) begin
            w_state    <= W_DATA;
            hp_awready <= 1'b0;
            hp_wready  <= 1'b1;
            w_idx      <= hp_awaddr[LSB +: IDX_W];
            w_len      <= hp_awlen;
            w_cnt      <= '0;
            w_err      <= aw_err;
            w_over     <= 1'b0;
          end else begin
            hp_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            wr_beat_count <= wr_beat_count + 32'd1;
            w_idx         <= w_idx + 1'b1;
            w_cnt         <= w_cnt + 8'd1;
            // w_over remembers a burst that ran past awlen+1 beats without wlast.
            if (hp_wlast) begin
              w_state   <= W_RESP;
              hp_wready <= 1'b0;
              hp_bvalid <= 1'b1;
              hp_bresp  <= (w_err || w_over || (w_cnt != w_len)) ? RESP_SLVERR : RESP_OKAY;
            end else if (w_cnt == w_len) begin
              w_over <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (hp_bready) begin
            w_state    <= W_IDLE;
            hp_bvalid  <= 1'b0;
            hp_bresp   <= RESP_OKAY;
            hp_awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= R_IDLE;
      hp_arready    <= 1'b0;
      hp_rvalid     <= 1'b0;
      hp_rlast      <= 1'b0;
      hp_rresp      <= RESP_OKAY;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      rd_beat_count <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (hp_arvalid && hp_arready) begin
            r_state    <= R_DATA;
            hp_arready <= 1'b0;
            hp_rvalid  <= 1'b1;
            hp_rlast   <= (hp_arlen == 8'd0);
            hp_rresp   <= ar_err ? RESP_SLVERR : RESP_OKAY;
            r_idx      <= hp_araddr[LSB +: IDX_W];
            r_len      <= hp_arlen;
            r_cnt      <= '0;
            r_err      <= ar_err;
          end else begin
            hp_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_beat) begin
            rd_beat_count <= rd_beat_count + 32'd1;
            if (hp_rlast) begin
              r_state    <= R_IDLE;
              hp_rvalid  <= 1'b0;
              hp_rlast   <= 1'b0;
              hp_rresp   <= RESP_OKAY;
              hp_arready <= 1'b1;
            end else begin
              r_idx    <= r_idx + 1'b1;
              r_cnt    <= r_cnt + 8'd1;
              hp_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Testbench for axi_mem_responder: table vectors, hand-written corner sequences and random
// bursts checked against a beat-level memory model.
module tb_axi_mem_responder;

  localparam int AW    = 48;
  localparam int DW    = 128;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [AW-1:0]   hp_awaddr = '0;
  logic [7:0]      hp_awlen = '0;
  logic [2:0]      hp_awsize = '0;
  logic [1:0]      hp_awburst = '0;
  logic            hp_awvalid = 1'b0;
  logic            hp_awready;
  logic [DW-1:0]   hp_wdata = '0;
  logic [DW/8-1:0] hp_wstrb = '0;
  logic            hp_wlast = 1'b0;
  logic            hp_wvalid = 1'b0;
  logic            hp_wready;
  logic [1:0]      hp_bresp;
  logic            hp_bvalid;
  logic            hp_bready = 1'b0;
  logic [AW-1:0]   hp_araddr = '0;
  logic [7:0]      hp_arlen = '0;
  logic [2:0]      hp_arsize = '0;
  logic [1:0]      hp_arburst = '0;
  logic            hp_arvalid = 1'b0;
  logic            hp_arready;
  logic [DW-1:0]   hp_rdata;
  logic [1:0]      hp_rresp;
  logic            hp_rlast;
  logic            hp_rvalid;
  logic            hp_rready = 1'b0;
  logic [31:0]     wr_beat_count;
  logic [31:0]     rd_beat_count;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .HP_ADDR_WIDTH(AW),
    .HP_DATA_WIDTH(DW),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn),
    .hp_awaddr(hp_awaddr), .hp_awlen(hp_awlen), .hp_awsize(hp_awsize), .hp_awburst(hp_awburst),
    .hp_awvalid(hp_awvalid), .hp_awready(hp_awready),
    .hp_wdata(hp_wdata), .hp_wstrb(hp_wstrb), .hp_wlast(hp_wlast), .hp_wvalid(hp_wvalid),
    .hp_wready(hp_wready),
    .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready),
    .hp_araddr(hp_araddr), .hp_arlen(hp_arlen), .hp_arsize(hp_arsize), .hp_arburst(hp_arburst),
    .hp_arvalid(hp_arvalid), .hp_arready(hp_arready),
    .hp_rdata(hp_rdata), .hp_rresp(hp_rresp), .hp_rlast(hp_rlast), .hp_rvalid(hp_rvalid),
    .hp_rready(hp_rready),
    .wr_beat_count(wr_beat_count), .rd_beat_count(rd_beat_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [1:0]    burst;
    logic [2:0]    size;
    int            nbeats;
    int            bstall;
    int            rstall_beat;
    int            rstall_cycles;
    logic [1:0]    exp_bresp;
    logic [1:0]    exp_rresp;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [31:0]   exp_wr = 0;
  logic [31:0]   exp_rd = 0;
  logic [DW-1:0] wbeat [DEPTH];
  logic [DW-1:0] rbeat [DEPTH];
  logic [1:0]    last_bresp;
  logic [1:0]    last_rresp;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [DW/8-1:0] strb);
    merge = old;
    for (int i = 0; i < DW/8; i++) if (strb[i]) merge[8*i +: 8] = nw[8*i +: 8];
  endfunction

  task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input logic [DW/8-1:0] strb,
                             input int bstall);
    logic [7:0] idx;
    logic       ok;
    logic [1:0] exp_resp;
    int         n;
    idx = addr[11:4];
    ok  = (burst == 2'b01) && (size == 3'b100);
    exp_resp = (ok && nbeats == len + 1) ? 2'b00 : 2'b10;
    hp_awaddr = addr; hp_awlen = 8'(len); hp_awburst = burst; hp_awsize = size; hp_awvalid = 1'b1;
    n = 0;
    while (hp_awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (hp_awready !== 1'b1) begin
      checkOutput("aw_timeout", DW'(hp_awready), DW'(1));
      hp_awvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    hp_awvalid = 1'b0;
    checkOutput("wready_after_aw", DW'(hp_wready), DW'(1));
    checkOutput("awready_busy", DW'(hp_awready), DW'(0));
    for (int b = 0; b < nbeats; b++) begin
      hp_wdata = wbeat[b]; hp_wstrb = strb; hp_wlast = (b == nbeats - 1); hp_wvalid = 1'b1;
      checkOutput("wready_beat", DW'(hp_wready), DW'(1));
      @(posedge clk); #1;
      if (ok) mem_m[idx] = merge(mem_m[idx], wbeat[b], strb);
      idx++;
    end
    hp_wvalid = 1'b0; hp_wlast = 1'b0;
    exp_wr += 32'(nbeats);
    checkOutput("bvalid_after_wlast", DW'(hp_bvalid), DW'(1));
    checkOutput("bresp", DW'(hp_bresp), DW'(exp_resp));
    checkOutput("wr_beat_count", DW'(wr_beat_count), DW'(exp_wr));
    last_bresp = hp_bresp;
    for (int s = 0; s < bstall; s++) begin
      hp_awvalid = 1'b1;
      @(posedge clk); #1;
      checkOutput("bvalid_hold", DW'(hp_bvalid), DW'(1));
      checkOutput("bresp_hold", DW'(hp_bresp), DW'(exp_resp));
      checkOutput("awready_blocked", DW'(hp_awready), DW'(0));
    end
    hp_awvalid = 1'b0;
    hp_bready = 1'b1;
    @(posedge clk); #1;
    hp_bready = 1'b0;
    checkOutput("bvalid_clear", DW'(hp_bvalid), DW'(0));
    checkOutput("awready_back", DW'(hp_awready), DW'(1));
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [2:0] size, input int stall_beat, input int stall_cycles);
    logic [7:0]    idx;
    logic          ok;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_data;
    int            n;
    idx = addr[11:4];
    ok  = (burst == 2'b01) && (size == 3'b100);
    exp_resp = ok ? 2'b00 : 2'b10;
    hp_araddr = addr; hp_arlen = 8'(len); hp_arburst = burst; hp_arsize = size; hp_arvalid = 1'b1;
    n = 0;
    while (hp_arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (hp_arready !== 1'b1) begin
      checkOutput("ar_timeout", DW'(hp_arready), DW'(1));
      hp_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    hp_arvalid = 1'b0;
    checkOutput("arready_busy", DW'(hp_arready), DW'(0));
    for (int b = 0; b <= len; b++) begin
      exp_data = ok ? mem_m[idx] : '0;
      checkOutput("rvalid", DW'(hp_rvalid), DW'(1));
      checkOutput("rdata", hp_rdata, exp_data);
      checkOutput("rresp", DW'(hp_rresp), DW'(exp_resp));
      checkOutput("rlast", DW'(hp_rlast), DW'(b == len));
      rbeat[b] = hp_rdata;
      if (b == 0) last_rresp = hp_rresp;
      if (b == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          hp_rready = 1'b0; hp_arvalid = 1'b1;
          @(posedge clk); #1;
          checkOutput("rvalid_hold", DW'(hp_rvalid), DW'(1));
          checkOutput("rdata_hold", hp_rdata, exp_data);
          checkOutput("rlast_hold", DW'(hp_rlast), DW'(b == len));
          checkOutput("arready_blocked", DW'(hp_arready), DW'(0));
        end
        hp_arvalid = 1'b0;
      end
      hp_rready = 1'b1;
      @(posedge clk); #1;
      hp_rready = 1'b0;
      idx++;
    end
    exp_rd += 32'(len + 1);
    checkOutput("rvalid_clear", DW'(hp_rvalid), DW'(0));
    checkOutput("arready_back", DW'(hp_arready), DW'(1));
    checkOutput("rd_beat_count", DW'(rd_beat_count), DW'(exp_rd));
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int b = 0; b < v.nbeats; b++) wbeat[b] = {$urandom, $urandom, $urandom, $urandom};
    write_burst(v.addr, v.len, v.burst, v.size, v.nbeats, '1, v.bstall);
    checkOutput("vec_bresp", DW'(last_bresp), DW'(v.exp_bresp));
    read_burst(v.addr, v.len, v.burst, v.size, v.rstall_beat, v.rstall_cycles);
    checkOutput("vec_rresp", DW'(last_rresp), DW'(v.exp_rresp));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t          vecs [7];
    logic [31:0]   rd_before;
    logic [AW-1:0] ra;
    int            rl;
    int            nb;
    logic [1:0]    rbu;
    logic [2:0]    rsz;

    vecs[0] = '{48'h1000,  3, 2'b01, 3'b100,  4,  0, -1, 0, 2'b00, 2'b00};
    vecs[1] = '{48'h2000,  0, 2'b01, 3'b100,  1,  2,  0, 3, 2'b00, 2'b00};
    vecs[2] = '{48'h3000,  7, 2'b00, 3'b100,  8,  0, -1, 0, 2'b10, 2'b10};
    vecs[3] = '{48'h4000,  7, 2'b01, 3'b100,  4,  0,  2, 1, 2'b10, 2'b00};
    vecs[4] = '{48'h5000,  1, 2'b01, 3'b010,  2,  0, -1, 0, 2'b10, 2'b10};
    vecs[5] = '{48'h6000, 15, 2'b01, 3'b100, 16, 10,  7, 5, 2'b00, 2'b00};
    vecs[6] = '{48'h7000,  2, 2'b01, 3'b100,  5,  0, -1, 0, 2'b10, 2'b00};

    #1;
    checkOutput("rst_awready", DW'(hp_awready), DW'(0));
    checkOutput("rst_arready", DW'(hp_arready), DW'(0));
    checkOutput("rst_wready", DW'(hp_wready), DW'(0));
    checkOutput("rst_bvalid", DW'(hp_bvalid), DW'(0));
    checkOutput("rst_rvalid", DW'(hp_rvalid), DW'(0));
    checkOutput("rst_rlast", DW'(hp_rlast), DW'(0));
    checkOutput("rst_resp", DW'({hp_bresp, hp_rresp}), DW'(0));
    checkOutput("rst_rdata", hp_rdata, '0);
    checkOutput("rst_counts", DW'({wr_beat_count, rd_beat_count}), DW'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready_first_cycle", DW'(hp_awready), DW'(1));
    checkOutput("arready_first_cycle", DW'(hp_arready), DW'(1));

    // Give every memory location a known value before any model comparison.
    for (int i = 0; i < DEPTH; i++) wbeat[i] = {$urandom, $urandom, $urandom, $urandom};
    write_burst(48'h0, 255, 2'b01, 3'b100, 256, '1, 0);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 4; i++) wbeat[i] = DW'(i + 1);
    write_burst(48'h1000, 3, 2'b01, 3'b100, 4, '1, 0);
    checkOutput("basic_bresp", DW'(last_bresp), DW'(0));
    rd_before = rd_beat_count;
    read_burst(48'h1000, 3, 2'b01, 3'b100, -1, 0);
    for (int i = 0; i < 4; i++) checkOutput("basic_rdata", rbeat[i], DW'(i + 1));
    checkOutput("basic_rd_delta", DW'(rd_beat_count - rd_before), DW'(4));

    wbeat[0] = '1;
    write_burst(48'h50, 0, 2'b01, 3'b100, 1, '1, 0);
    wbeat[0] = '0;
    write_burst(48'h50, 0, 2'b01, 3'b100, 1, 16'h000F, 0);
    read_burst(48'h50, 0, 2'b01, 3'b100, -1, 0);
    checkOutput("partial_strobe", rbeat[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    wbeat[0] = 128'h1234;
    write_burst(48'h50, 0, 2'b00, 3'b100, 1, '1, 0);
    checkOutput("err_bresp", DW'(last_bresp), DW'(2'b10));
    read_burst(48'h50, 0, 2'b01, 3'b100, -1, 0);
    checkOutput("err_mem_unchanged", rbeat[0], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);

    wbeat[0] = 128'hAAAA_0255; wbeat[1] = 128'hBBBB_0000;
    write_burst(48'hFF0, 1, 2'b01, 3'b100, 2, '1, 0);
    read_burst(48'hFF0, 0, 2'b01, 3'b100, -1, 0);
    checkOutput("wrap_idx255", rbeat[0], 128'hAAAA_0255);
    read_burst(48'h0, 0, 2'b01, 3'b100, -1, 0);
    checkOutput("wrap_idx0", rbeat[0], 128'hBBBB_0000);

    // Reset while the write FSM waits for data: burst dropped, counters cleared.
    hp_awaddr = 48'h80; hp_awlen = 8'd3; hp_awburst = 2'b01; hp_awsize = 3'b100; hp_awvalid = 1'b1;
    @(posedge clk); #1;
    hp_awvalid = 1'b0;
    checkOutput("midrst_wready_before", DW'(hp_wready), DW'(1));
    rstn = 1'b0;
    #1;
    checkOutput("midrst_wready", DW'(hp_wready), DW'(0));
    checkOutput("midrst_bvalid", DW'(hp_bvalid), DW'(0));
    checkOutput("midrst_awready", DW'(hp_awready), DW'(0));
    checkOutput("midrst_counts", DW'({wr_beat_count, rd_beat_count}), DW'(0));
    exp_wr = 0; exp_rd = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_awready_back", DW'(hp_awready), DW'(1));
    read_burst(48'h80, 0, 2'b01, 3'b100, -1, 0);

    for (int it = 0; it < 40; it++) begin
      rl  = $urandom_range(0, 15);
      rbu = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      rsz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      nb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, rl + 2)) : rl + 1;
      ra  = {16'($urandom), $urandom};
      for (int b = 0; b < nb; b++) wbeat[b] = {$urandom, $urandom, $urandom, $urandom};
      write_burst(ra, rl, rbu, rsz, nb, ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1,
                  $urandom_range(0, 3));
      rl  = $urandom_range(0, 15);
      rbu = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      rsz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      ra  = ($urandom_range(0, 1) == 0) ? ra : {16'($urandom), $urandom};
      read_burst(ra, rl, rbu, rsz, $urandom_range(0, rl), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
